// File: rtl/random_target_gen.sv
// random_target_gen: LFSR-driven target position/colour picker
// with request handshake, bounded redraws and optional no-repeat.
module random_target_gen #(
  parameter int unsigned       NPOS      = 16,
  parameter int unsigned       IDXW      = 4,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int unsigned       NCOLORS   = 3,
  parameter int unsigned       CW        = 2,
  parameter int unsigned       MAX_TRY   = 7,
  parameter bit                NO_REPEAT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              remake_i,
  input  logic              color_mode_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_in_i,
  output logic [NPOS:0]     position_o,
  output logic [CW-1:0]     color_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic [15:0]       draw_cnt_o
);

  localparam int unsigned TW =
    (MAX_TRY < 1) ? 1 : $clog2(MAX_TRY + 1);

  localparam logic [TW-1:0]   MAX_T    = TW'(MAX_TRY);
  localparam logic [IDXW-1:0] LAST_POS = IDXW'(NPOS - 1);
  localparam logic [CW-1:0]   NCOL     = CW'(NCOLORS);
  localparam logic [CW-1:0]   COL_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [TW-1:0]     try_q, try_d;
  logic              mode_q, mode_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic              last_vld_q, last_vld_d;
  logic [CW-1:0]     col_cnt_q, col_cnt_d;
  logic [NPOS:0]     pos_q, pos_d;
  logic [CW-1:0]     color_q, color_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [IDXW-1:0]   cand;
  logic              out_rng;
  logic              is_rep;
  logic              rej;
  logic [IDXW-1:0]   fb_idx;
  logic [IDXW-1:0]   idx;
  logic [CW-1:0]     rnd;
  logic              rnd_ok;
  logic [CW-1:0]     col_next;

  // LFSR free-runs; a seed load overrides the shift, zero maps to SEED
  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    if (seed_load_i) begin
      lfsr_d = (seed_in_i == '0) ? SEED : seed_in_i;
    end
  end

  // candidate qualification, fallback index and colour pick
  always_comb begin
    cand     = lfsr_q[IDXW-1:0];
    out_rng  = (32'(cand) >= NPOS);
    is_rep   = NO_REPEAT && last_vld_q && (cand == last_q);
    rej      = out_rng || is_rep;
    fb_idx   = '0;
    if (last_vld_q && (last_q != LAST_POS)) begin
      fb_idx = last_q + 1'b1;
    end
    idx      = rej ? fb_idx : cand;
    rnd      = lfsr_q[LFSR_W-1 -: CW];
    rnd_ok   = (rnd != '0) && (32'(rnd) <= NCOLORS);
    col_next = (col_cnt_q == NCOL) ? COL_ONE : col_cnt_q + 1'b1;
  end

  // draw sequencer: next state and registered output updates
  always_comb begin
    state_d    = state_q;
    try_d      = try_q;
    mode_d     = mode_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    col_cnt_d  = col_cnt_q;
    pos_d      = pos_q;
    color_d    = color_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (remake_i) begin
          state_d = S_DRAW;
          busy_d  = 1'b1;
          try_d   = '0;
          mode_d  = color_mode_i;
        end
      end
      S_DRAW: begin
        if (rej && (try_q != MAX_T)) begin
          try_d = try_q + 1'b1;
        end else begin
          state_d    = S_DONE;
          pos_d      = (NPOS+1)'(2) << idx;
          last_d     = idx;
          last_vld_d = 1'b1;
          valid_d    = 1'b1;
          busy_d     = 1'b0;
          cnt_d      = cnt_q + 16'd1;
          color_d    = (mode_q && rnd_ok) ? rnd : col_cnt_q;
          // the cyclic counter only moves when cyclic mode is used
          if (!mode_q) begin
            col_cnt_d = col_next;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      try_q      <= '0;
      mode_q     <= 1'b0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      col_cnt_q  <= COL_ONE;
      pos_q      <= '0;
      color_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      try_q      <= try_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      col_cnt_q  <= col_cnt_d;
      pos_q      <= pos_d;
      color_q    <= color_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign position_o = pos_q;
  assign color_o    = color_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign draw_cnt_o = cnt_q;

endmodule
